// File: rtl/oled_spi_sink.sv
// Display-side receiver for the OLED serial link: samples CS/SCLK/SDO/DC, decodes page/column
// commands and stores data bytes into a 4-page x 128-column framebuffer with registered readback.
//
// decoder state | meaning
// D_IDLE        | next command byte is an opcode
// D_PAGE_ARG    | next command byte is the page argument of 0x22
module oled_spi_sink #(
   parameter int SCLK_MIN_HALF = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CS,
   input  logic       SCLK,
   input  logic       SDO,
   input  logic       DC,
   input  logic [8:0] RD_ADDR,
   output logic [7:0] RD_DATA,
   output logic       BYTE_VALID,
   output logic [7:0] BYTE_OUT,
   output logic       BYTE_DC,
   output logic [1:0] CUR_PAGE,
   output logic [6:0] CUR_COL,
   output logic       FRAME_DONE,
   output logic       BAD_CMD
);

   if (SCLK_MIN_HALF < 1) begin : g_bad_param
      $error("SCLK_MIN_HALF must be at least 1");
   end

   typedef enum logic {
      D_IDLE     = 1'b0,
      D_PAGE_ARG = 1'b1
   } dec_state_e;

   logic [1:0] cs_sync_q, cs_sync_d;
   logic [2:0] sclk_sync_q, sclk_sync_d;
   logic [1:0] sdo_sync_q, sdo_sync_d;
   logic [1:0] dc_sync_q, dc_sync_d;
   logic       cs_s, sdo_s, dc_s, sclk_rise;

   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       done_q, done_d;
   logic [7:0] done_byte_q, done_byte_d;
   logic       done_dc_q, done_dc_d;

   dec_state_e state_q, state_d;
   logic [1:0] page_q, page_d;
   logic [6:0] col_q, col_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] byte_out_q, byte_out_d;
   logic       byte_dc_q, byte_dc_d;
   logic       frame_done_q, frame_done_d;
   logic       bad_cmd_q, bad_cmd_d;
   logic [7:0] rd_data_q, rd_data_d;

   logic       fb_we;
   logic [8:0] fb_waddr;
   logic [7:0] fb_mem [0:511];

   // All four pins see the same synchroniser depth so SDO/DC line up with the detected SCLK edge.
   always_comb begin
      cs_sync_d   = {cs_sync_q[0], CS};
      sclk_sync_d = {sclk_sync_q[1:0], SCLK};
      sdo_sync_d  = {sdo_sync_q[0], SDO};
      dc_sync_d   = {dc_sync_q[0], DC};
   end

   assign cs_s      = cs_sync_q[1];
   assign sdo_s     = sdo_sync_q[1];
   assign dc_s      = dc_sync_q[1];
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];

   always_comb begin
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      done_d      = 1'b0;
      done_byte_d = done_byte_q;
      done_dc_d   = done_dc_q;
      if (cs_s) begin
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (sclk_rise) begin
         shift_d   = {shift_q[6:0], sdo_s};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            done_d      = 1'b1;
            done_byte_d = {shift_q[6:0], sdo_s};
            done_dc_d   = dc_s;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cs_sync_q   <= '0;
         sclk_sync_q <= '0;
         sdo_sync_q  <= '0;
         dc_sync_q   <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         done_q      <= 1'b0;
         done_byte_q <= '0;
         done_dc_q   <= 1'b0;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         sdo_sync_q  <= sdo_sync_d;
         dc_sync_q   <= dc_sync_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         done_q      <= done_d;
         done_byte_q <= done_byte_d;
         done_dc_q   <= done_dc_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= D_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A data byte always drops a pending page argument.
   always_comb begin
      state_d = state_q;
      if (done_q) begin
         if (done_dc_q || state_q == D_PAGE_ARG) begin
            state_d = D_IDLE;
         end else if (done_byte_q == 8'h22) begin
            state_d = D_PAGE_ARG;
         end
      end
   end

   always_comb begin
      page_d       = page_q;
      col_d        = col_q;
      byte_valid_d = done_q;
      byte_out_d   = byte_out_q;
      byte_dc_d    = byte_dc_q;
      frame_done_d = 1'b0;
      bad_cmd_d    = 1'b0;
      fb_we        = 1'b0;
      fb_waddr     = {page_q, col_q};
      if (done_q) begin
         byte_out_d = done_byte_q;
         byte_dc_d  = done_dc_q;
         if (done_dc_q) begin
            fb_we        = 1'b1;
            col_d        = col_q + 7'd1;
            frame_done_d = (page_q == 2'd3) && (col_q == 7'd127);
         end else if (state_q == D_PAGE_ARG) begin
            page_d = done_byte_q[1:0];
         end else if (done_byte_q != 8'h22) begin
            if (done_byte_q[7:4] == 4'h0) begin
               col_d[3:0] = done_byte_q[3:0];
            end else if (done_byte_q[7:3] == 5'b00010) begin
               col_d[6:4] = done_byte_q[2:0];
            end else if (done_byte_q[7:2] == 6'b101100) begin
               page_d = done_byte_q[1:0];
            end else begin
               bad_cmd_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         page_q       <= '0;
         col_q        <= '0;
         byte_valid_q <= 1'b0;
         byte_out_q   <= '0;
         byte_dc_q    <= 1'b0;
         frame_done_q <= 1'b0;
         bad_cmd_q    <= 1'b0;
      end else begin
         page_q       <= page_d;
         col_q        <= col_d;
         byte_valid_q <= byte_valid_d;
         byte_out_q   <= byte_out_d;
         byte_dc_q    <= byte_dc_d;
         frame_done_q <= frame_done_d;
         bad_cmd_q    <= bad_cmd_d;
      end
   end

   // Framebuffer contents are deliberately not reset; the read register samples old data on a collision.
   always_ff @(posedge CLK) begin
      if (fb_we) begin
         fb_mem[fb_waddr] <= done_byte_q;
      end
   end

   always_comb begin
      rd_data_d = fb_mem[RD_ADDR];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign RD_DATA    = rd_data_q;
   assign BYTE_VALID = byte_valid_q;
   assign BYTE_OUT   = byte_out_q;
   assign BYTE_DC    = byte_dc_q;
   assign CUR_PAGE   = page_q;
   assign CUR_COL    = col_q;
   assign FRAME_DONE = frame_done_q;
   assign BAD_CMD    = bad_cmd_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Bench for oled_spi_sink: drives the serial link on CLK falling edges, scoreboards every
// completed byte and checks decoder state and framebuffer readback per scenario.
module tb_oled_spi_sink;

   localparam int HALF = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CS = 1'b1;
   logic       SCLK = 1'b0;
   logic       SDO = 1'b0;
   logic       DC = 1'b0;
   logic [8:0] RD_ADDR = '0;
   logic [7:0] RD_DATA;
   logic       BYTE_VALID;
   logic [7:0] BYTE_OUT;
   logic       BYTE_DC;
   logic [1:0] CUR_PAGE;
   logic [6:0] CUR_COL;
   logic       FRAME_DONE;
   logic       BAD_CMD;

   oled_spi_sink #(.SCLK_MIN_HALF(HALF)) dut (
      .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .SDO(SDO), .DC(DC),
      .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .BYTE_VALID(BYTE_VALID),
      .BYTE_OUT(BYTE_OUT), .BYTE_DC(BYTE_DC), .CUR_PAGE(CUR_PAGE),
      .CUR_COL(CUR_COL), .FRAME_DONE(FRAME_DONE), .BAD_CMD(BAD_CMD)
   );

   always #5 CLK = ~CLK;

   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         bv_cnt = 0;
   int         fd_cnt = 0;
   int         bad_cnt = 0;
   int         bv_cyc = 0;
   int         rise_cyc = 0;
   logic [7:0] fd_byte = '0;
   logic [8:0] exp_q [$];

   always @(posedge CLK) cyc++;

   // Byte scoreboard: expected {dc, byte} pushed by the driver, popped on each BYTE_VALID.
   always @(negedge CLK) begin
      if (!RST) begin
         if (BYTE_VALID) begin
            logic [8:0] e;
            bv_cnt++;
            bv_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL byte_unexpected got dc=%0b byte=%02h, none expected", BYTE_DC, BYTE_OUT);
            end else begin
               e = exp_q.pop_front();
               if ({BYTE_DC, BYTE_OUT} !== e) begin
                  n_err++;
                  $display("FAIL byte_stream got dc=%0b byte=%02h, expected dc=%0b byte=%02h",
                           BYTE_DC, BYTE_OUT, e[8], e[7:0]);
               end
            end
         end
         if (FRAME_DONE) begin
            fd_cnt++;
            fd_byte = BYTE_OUT;
         end
         if (BAD_CMD) bad_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   task automatic cs_low();
      @(negedge CLK);
      CS = 1'b0;
      repeat (HALF) @(negedge CLK);
   endtask

   task automatic cs_high();
      repeat (2) @(negedge CLK);
      CS = 1'b1;
      repeat (6) @(negedge CLK);
   endtask

   task automatic shift_byte(input logic [7:0] b, input logic dc, input int nbits);
      if (nbits == 8) exp_q.push_back({dc, b});
      DC = dc;
      for (int i = 0; i < nbits; i++) begin
         SDO = b[7-i];
         repeat (HALF) @(negedge CLK);
         SCLK = 1'b1;
         rise_cyc = cyc;
         repeat (HALF) @(negedge CLK);
         SCLK = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc);
      cs_low();
      shift_byte(b, dc, 8);
      cs_high();
   endtask

   task automatic read_fb(input logic [8:0] a, output logic [7:0] d);
      @(negedge CLK);
      RD_ADDR = a;
      @(negedge CLK);
      d = RD_DATA;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      n_cmp++;
      if ({RD_DATA, BYTE_VALID, BYTE_OUT, BYTE_DC, CUR_PAGE, CUR_COL, FRAME_DONE, BAD_CMD} !== 30'd0) begin
         n_err++;
         $display("FAIL reset_values got rd=%02h bv=%0b out=%02h dc=%0b pg=%0d col=%0d fd=%0b bad=%0b, expected all 0",
                  RD_DATA, BYTE_VALID, BYTE_OUT, BYTE_DC, CUR_PAGE, CUR_COL, FRAME_DONE, BAD_CMD);
      end
      RST = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_basic();
      int bv0;
      logic [7:0] d;
      bv0 = bv_cnt;
      send_byte(8'h22, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'hA5, 1'b1);
      n_cmp++;
      if (bv_cnt - bv0 != 5) begin
         n_err++; $display("FAIL basic_pulses got %0d, expected 5", bv_cnt - bv0);
      end
      n_cmp++;
      if (bv_cyc - rise_cyc != 4) begin
         n_err++; $display("FAIL basic_latency got %0d, expected 4", bv_cyc - rise_cyc);
      end
      n_cmp++;
      if (CUR_PAGE !== 2'd2 || CUR_COL !== 7'd1) begin
         n_err++; $display("FAIL basic_addr got page=%0d col=%0d, expected page=2 col=1", CUR_PAGE, CUR_COL);
      end
      read_fb(9'h100, d);
      n_cmp++;
      if (d !== 8'hA5) begin
         n_err++; $display("FAIL basic_fb got %02h, expected a5", d);
      end
   endtask

   task automatic test_frame_wrap();
      int fd0;
      logic [7:0] d;
      fd0 = fd_cnt;
      send_byte(8'hB3, 1'b0);
      send_byte(8'h0E, 1'b0);
      send_byte(8'h17, 1'b0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      n_cmp++;
      if (fd_cnt - fd0 != 1 || fd_byte !== 8'h22) begin
         n_err++; $display("FAIL frame_done got count=%0d byte=%02h, expected count=1 byte=22", fd_cnt - fd0, fd_byte);
      end
      n_cmp++;
      if (CUR_PAGE !== 2'd3 || CUR_COL !== 7'd1) begin
         n_err++; $display("FAIL frame_addr got page=%0d col=%0d, expected page=3 col=1", CUR_PAGE, CUR_COL);
      end
      read_fb(9'h1FE, d);
      n_cmp++;
      if (d !== 8'h11) begin n_err++; $display("FAIL frame_fb_1fe got %02h, expected 11", d); end
      read_fb(9'h1FF, d);
      n_cmp++;
      if (d !== 8'h22) begin n_err++; $display("FAIL frame_fb_1ff got %02h, expected 22", d); end
      read_fb(9'h180, d);
      n_cmp++;
      if (d !== 8'h33) begin n_err++; $display("FAIL frame_fb_180 got %02h, expected 33", d); end
   endtask

   task automatic test_cs_abort();
      int bv0;
      logic [7:0] d;
      bv0 = bv_cnt;
      cs_low();
      shift_byte(8'hF0, 1'b1, 5);
      cs_high();
      n_cmp++;
      if (bv_cnt != bv0) begin
         n_err++; $display("FAIL abort_no_pulse got %0d pulses, expected 0", bv_cnt - bv0);
      end
      send_byte(8'h3C, 1'b1);
      read_fb(9'h181, d);
      n_cmp++;
      if (d !== 8'h3C || CUR_COL !== 7'd2) begin
         n_err++; $display("FAIL abort_next_byte got fb=%02h col=%0d, expected fb=3c col=2", d, CUR_COL);
      end
   endtask

   task automatic test_page_arg_cancel();
      int bad0;
      logic [7:0] d;
      bad0 = bad_cnt;
      send_byte(8'h22, 1'b0);
      send_byte(8'h77, 1'b1);
      read_fb(9'h182, d);
      n_cmp++;
      if (d !== 8'h77 || CUR_PAGE !== 2'd3 || CUR_COL !== 7'd3) begin
         n_err++; $display("FAIL cancel_write got fb=%02h page=%0d col=%0d, expected fb=77 page=3 col=3", d, CUR_PAGE, CUR_COL);
      end
      send_byte(8'hB1, 1'b0);
      n_cmp++;
      if (CUR_PAGE !== 2'd1 || bad_cnt != bad0) begin
         n_err++; $display("FAIL cancel_idle got page=%0d bad=%0d, expected page=1 bad=0", CUR_PAGE, bad_cnt - bad0);
      end
   endtask

   task automatic test_bad_cmd();
      int bad0;
      logic [7:0] d;
      send_byte(8'h99, 1'b1);
      send_byte(8'h03, 1'b0);
      bad0 = bad_cnt;
      send_byte(8'hAF, 1'b0);
      n_cmp++;
      if (bad_cnt - bad0 != 1) begin
         n_err++; $display("FAIL bad_pulse got %0d, expected 1", bad_cnt - bad0);
      end
      read_fb(9'h083, d);
      n_cmp++;
      if (d !== 8'h99 || CUR_PAGE !== 2'd1 || CUR_COL !== 7'd3) begin
         n_err++; $display("FAIL bad_state got fb=%02h page=%0d col=%0d, expected fb=99 page=1 col=3", d, CUR_PAGE, CUR_COL);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v [4];
      logic [7:0] d;
      cs_low();
      for (int i = 0; i < 4; i++) begin
         v[i] = 8'($urandom_range(0, 255));
         shift_byte(v[i], 1'b1, 8);
      end
      cs_high();
      n_cmp++;
      if (CUR_COL !== 7'd7) begin
         n_err++; $display("FAIL b2b_col got %0d, expected 7", CUR_COL);
      end
      for (int i = 0; i < 4; i++) begin
         read_fb(9'h083 + 9'(i), d);
         n_cmp++;
         if (d !== v[i]) begin
            n_err++; $display("FAIL b2b_fb[%0d] got %02h, expected %02h", i, d, v[i]);
         end
      end
   endtask

   task automatic test_read_first();
      bit seen;
      send_byte(8'hB0, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h00, 1'b0);
      @(negedge CLK);
      RD_ADDR = 9'h000;
      seen = 1'b0;
      fork
         send_byte(8'hC3, 1'b1);
         begin
            for (int k = 0; k < 400 && !seen; k++) begin
               @(negedge CLK);
               if (BYTE_VALID) seen = 1'b1;
            end
            n_cmp++;
            if (!seen) begin
               n_err++; $display("FAIL rf_timeout got no BYTE_VALID, expected one within 400 cycles");
            end else begin
               if (RD_DATA !== 8'h5A) begin
                  n_err++; $display("FAIL rf_old got %02h, expected 5a", RD_DATA);
               end
               @(negedge CLK);
               n_cmp++;
               if (RD_DATA !== 8'hC3) begin
                  n_err++; $display("FAIL rf_new got %02h, expected c3", RD_DATA);
               end
            end
         end
      join
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      send_byte(8'h22, 1'b0);
      cs_low();
      shift_byte(8'hE7, 1'b1, 4);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      n_cmp++;
      if ({RD_DATA, BYTE_VALID, BYTE_OUT, BYTE_DC, CUR_PAGE, CUR_COL, FRAME_DONE, BAD_CMD} !== 30'd0) begin
         n_err++;
         $display("FAIL midreset_values got rd=%02h bv=%0b out=%02h dc=%0b pg=%0d col=%0d, expected all 0",
                  RD_DATA, BYTE_VALID, BYTE_OUT, BYTE_DC, CUR_PAGE, CUR_COL);
      end
      CS = 1'b1;
      SCLK = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      send_byte(8'h01, 1'b0);
      send_byte(8'h5E, 1'b1);
      n_cmp++;
      if (CUR_PAGE !== 2'd0 || CUR_COL !== 7'd2) begin
         n_err++; $display("FAIL midreset_decode got page=%0d col=%0d, expected page=0 col=2", CUR_PAGE, CUR_COL);
      end
      read_fb(9'h001, d);
      n_cmp++;
      if (d !== 8'h5E) begin n_err++; $display("FAIL midreset_fb1 got %02h, expected 5e", d); end
      read_fb(9'h000, d);
      n_cmp++;
      if (d !== 8'hC3) begin n_err++; $display("FAIL midreset_fb0 got %02h, expected c3", d); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frame_wrap();
      test_cs_abort();
      test_page_arg_cancel();
      test_bad_cmd();
      test_back_to_back();
      test_read_first();
      test_reset_mid();
      repeat (4) @(negedge CLK);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL scoreboard_drain got %0d bytes outstanding, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/oled_spi_sink.md
# oled_spi_sink

SPI receiver and command decoder for the OLED serial link: the display-side end of the CS/SDO/SCLK/DC stream that the OLED driver transmits. It samples each byte and interprets command bytes (DC=0) that set the page and column. Data bytes (DC=1) go into a 4-page × 128-column byte framebuffer, which has a registered readback port. It serves on-board loopback self-test and display mirroring.

## Interface
- SCLK_MIN_HALF, default 3: minimum SCLK high/low time in CLK cycles that the bench and system guarantee. Documentation only; not checked.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CS  in  1  chip select, active-low, asynchronous to CLK.
- SCLK  in  1  serial clock, idle high or low, asynchronous to CLK.
- SDO  in  1  serial data, MSB first, sampled on the SCLK rising edge.
- DC  in  1  0 = command byte, 1 = data byte; sampled with the last bit of the byte.
- RD_ADDR  in  9  framebuffer read address {page[1:0], col[6:0]}.
- RD_DATA  out  8  framebuffer byte at the RD_ADDR presented in the previous cycle.
- BYTE_VALID  out  1  one-cycle pulse per completed byte.
- BYTE_OUT  out  8  last completed byte; held until the next byte completes.
- BYTE_DC  out  1  DC value of BYTE_OUT.
- CUR_PAGE  out  2  current write page.
- CUR_COL  out  7  current write column.
- FRAME_DONE  out  1  one-cycle pulse when a data byte is written at page 3, column 127.
- BAD_CMD  out  1  one-cycle pulse on an unrecognised command byte.

## Operation
- **Input synchronisation:** CS, SCLK, SDO and DC each pass through a 2-flop synchroniser of equal depth. A third SCLK flop provides rising-edge detect. SDO and DC are taken from the synchronised copies in the same cycle the edge is detected.
- **Shift register:**
  - Active only while synchronised CS=0.
  - On each detected SCLK rise, shift SDO in at the LSB and increment a 3-bit bit counter.
  - When the counter wraps from 7 to 0, the byte is complete: BYTE_OUT and BYTE_DC load, and BYTE_VALID pulses.
- **CS behaviour:**
  - CS high clears the bit counter and the shift register.
  - A partial byte is discarded silently with no pulse.
  - Decoder state (page, column, pending argument) persists across CS toggles, because the transmitter frames every byte with its own CS.
- **Decoder FSM** (states D_IDLE, D_PAGE_ARG). Acts in the cycle a byte completes:
  - D_IDLE, DC=0, byte 0x22: go to D_PAGE_ARG.
  - D_IDLE, DC=0, byte 0x00–0x0F: CUR_COL[3:0] ← byte[3:0].
  - D_IDLE, DC=0, byte 0x10–0x17: CUR_COL[6:4] ← byte[2:0].
  - D_IDLE, DC=0, byte 0xB0–0xB3: CUR_PAGE ← byte[1:0].
  - D_IDLE, DC=0, any other byte: BAD_CMD pulses and state is unchanged.
  - D_PAGE_ARG, DC=0, any byte: CUR_PAGE ← byte[1:0], then return to D_IDLE. Upper bits are ignored.
  - Any state, DC=1: write the byte to fb[{CUR_PAGE, CUR_COL}]. CUR_COL increments and wraps from 127 to 0 with CUR_PAGE unchanged (page addressing). If the write was at page 3, column 127, FRAME_DONE pulses. A DC=1 byte in D_PAGE_ARG also cancels the pending argument (state returns to D_IDLE).
- **Framebuffer:**
  - 512×8, single write port, one registered read port (block-RAM inferable).
  - Contents are not reset.
  - Read-during-write to the same address returns the old data (read-first).

## Timing
- Reset values: RD_DATA=0, BYTE_VALID=0, BYTE_OUT=0, BYTE_DC=0, CUR_PAGE=0, CUR_COL=0, FRAME_DONE=0, BAD_CMD=0, FSM=D_IDLE, bit counter=0, synchronisers=0.
- Reset asserted mid-byte or mid-argument discards everything. The first full byte after release decodes from D_IDLE.
- Latency:
  - BYTE_VALID rises exactly 3 CLK edges after the CLK edge that first samples the 8th SCLK rise at the pin.
  - The framebuffer write, CUR_COL/CUR_PAGE update, FRAME_DONE and BAD_CMD all occur on that same edge.
- Readback: RD_DATA is valid 1 cycle after RD_ADDR. A read at the written address issued in the cycle after BYTE_VALID returns the new byte.
- SCLK high and low phases must each be ≥ SCLK_MIN_HALF CLK cycles. CS must be low for ≥ 3 CLK cycles before the first SCLK rise.
- Consecutive bytes are never closer than 8 SCLK periods apart, so no back-pressure exists. No output other than RD_DATA depends on RD_ADDR.

## Test plan
- Reset, then send DC=0 bytes 0x22, 0x02, 0x00, 0x10, then DC=1 byte 0xA5 -> CUR_PAGE=2; fb[0x100]=0xA5; CUR_COL=1; 4 BYTE_VALID pulses with BYTE_DC 0,0,0,0 followed by one with BYTE_DC=1.
- Set page 3 via 0xB3 and column 126 via 0x0E, 0x17, then send data 0x11, 0x22, 0x33 -> fb[0x1FE]=0x11, fb[0x1FF]=0x22, fb[0x180]=0x33; FRAME_DONE pulses once, on the 0x22 write; CUR_COL ends at 1 with CUR_PAGE=3.
- Deassert CS after 5 bits, then send full DC=1 byte 0x3C -> no pulse for the partial byte; the byte 0x3C is received intact and written at the current address.
- Send DC=0 byte 0x22, then DC=1 byte 0x77 -> 0x77 is written at the current address; page is unchanged; FSM is back in D_IDLE, so the next command byte 0xB1 sets page 1.
- Send DC=0 byte 0xAF -> BAD_CMD pulses once; page and column are unchanged; no write.
- Assert RST between bits 3 and 4 of a DC=1 byte -> all outputs return to their reset values; no framebuffer write; the next byte decodes normally.
